// File: rtl/acia.sv
// acia: 6850-style serial port, fixed 8N1, bit timing from the pclk strobe.
// Build with ACIA_RX_EN defined to include the receiver; TX-only otherwise.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   pclk     one-cycle tick enable for bit timing
//   cs_n     chip select, active low
//   we_n     0 = write, 1 = read
//   rs       0 = control/status, 1 = tx/rx data
//   rx       serial input, idle high
//   din      cpu write data
//   dout     registered read data
//   tx       serial output, idle high
//   irq_n    interrupt request, active low
module acia #(
  parameter int clk_freq = 3333333,
  parameter int baudrate = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pclk,
  input  logic       cs_n,
  input  logic       we_n,
  input  logic       rs,
  input  logic       rx,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       tx,
  output logic       irq_n
);

  localparam int DIV = (clk_freq + baudrate / 2) / baudrate;
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TMAX = CW'(DIV - 1);

  logic wr, rd, wr_ctrl, wr_data;
  logic mres, srst;

  assign wr      = !cs_n && !we_n;
  assign rd      = !cs_n && we_n;
  assign wr_ctrl = wr && !rs;
  assign wr_data = wr && rs;
  // master reset behaves exactly like reset_n for all tx/rx state
  assign mres    = wr_ctrl && (din[1:0] == 2'b11);
  assign srst    = !reset_n || mres;

  logic [7:0] ctrl;
  logic       tie, rie;

  always_ff @(posedge clk) begin
    if (srst) ctrl <= '0;
    else if (wr_ctrl) ctrl <= din;
  end

  assign tie = (ctrl[6:5] == 2'b01);
  assign rie = ctrl[7];

  // transmitter
  typedef enum logic { TX_IDLE, TX_SEND } tx_state_t;

  tx_state_t       tx_state, tx_next;
  logic [CW-1:0]   tx_tick;
  logic [3:0]      tx_cnt;
  logic [9:0]      tx_frame;
  logic [7:0]      thr;
  logic            tdre;
  logic            tx_load;

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tdre) begin
          tx_load = 1'b1;
          tx_next = TX_SEND;
        end
      end
      TX_SEND: begin
        if (pclk && tx_tick == TMAX && tx_cnt == 4'd9)
          tx_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_cnt   <= '0;
      tx_frame <= '1;
      tdre     <= 1'b1;
      thr      <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_load) begin
        tx_frame <= {1'b1, thr, 1'b0};
        tx_tick  <= '0;
        tx_cnt   <= '0;
      end else if (tx_state == TX_SEND && pclk) begin
        if (tx_tick == TMAX) begin
          tx_tick  <= '0;
          tx_cnt   <= tx_cnt + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
        end else begin
          tx_tick <= tx_tick + CW'(1);
        end
      end
      if (tx_load) tdre <= 1'b1;
      // a cpu write on the transfer edge wins: new byte pending
      if (wr_data) begin
        thr  <= din;
        tdre <= 1'b0;
      end
    end
  end

  assign tx = tx_frame[0];

  // receiver
  logic       rdrf, fe, ovrn;
  logic [7:0] rdr;
  logic       unused;

`ifdef ACIA_RX_EN
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_tick;
  logic [2:0]    rx_cnt;
  logic [7:0]    rx_sh;
  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_half, rx_full, rx_done;
  logic          rd_data;

  assign rd_data = rd && rs;
  assign rx_half = pclk && (rx_tick == HALF);
  assign rx_full = pclk && (rx_tick == TMAX);

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_s3 && !rx_s2) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_full && rx_cnt == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (rx_full) begin
          rx_done = 1'b1;
          rx_next = RX_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rdr      <= '0;
      rdrf     <= 1'b0;
      fe       <= 1'b0;
      ovrn     <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_next;
      if (rx_next != rx_state || rx_state == RX_IDLE || rx_full)
        rx_tick <= '0;
      else if (pclk)
        rx_tick <= rx_tick + CW'(1);
      if (rx_state == RX_START)
        rx_cnt <= '0;
      else if (rx_state == RX_DATA && rx_full)
        rx_cnt <= rx_cnt + 3'd1;
      if (rx_state == RX_DATA && rx_full)
        rx_sh <= {rx_s2, rx_sh[7:1]};
      if (rd_data) begin
        rdrf <= 1'b0;
        fe   <= 1'b0;
        ovrn <= 1'b0;
      end
      // completion beats a same-edge read; ovrn uses pre-edge rdrf
      if (rx_done) begin
        rdr  <= rx_sh;
        fe   <= ~rx_s2;
        ovrn <= rdrf;
        rdrf <= 1'b1;
      end
    end
  end

  assign unused = ^ctrl[4:0];
`else
  assign rdrf   = 1'b0;
  assign fe     = 1'b0;
  assign ovrn   = 1'b0;
  assign rdr    = '0;
  assign unused = ^{ctrl[4:0], rx};
`endif

  logic       irq;
  logic [7:0] status;

  assign irq    = (rie && (rdrf || ovrn)) || (tie && tdre);
  assign irq_n  = ~irq;
  assign status = {irq, 1'b0, ovrn, fe, 2'b00, tdre, rdrf};

  always_ff @(posedge clk) begin
    if (!reset_n) dout <= '0;
    else if (rd) dout <= rs ? rdr : status;
  end

endmodule

// File: tb/tb_acia.sv
// tb_acia: directed self-checking bench for the acia serial port.
// Runs with a small divider (DIV = 5) and a pclk strobe every 3rd clk.
module tb_acia;

  localparam int DIV = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pclk = 1'b0;
  logic       cs_n, we_n, rs, rx;
  logic [7:0] din;
  logic [7:0] dout;
  logic       tx, irq_n;

  int errs = 0;
  int checks = 0;
  int tick_count = 0;
  int pph = 0;

  acia #(.clk_freq(10), .baudrate(2)) dut (
    .clk(clk), .reset_n(reset_n), .pclk(pclk),
    .cs_n(cs_n), .we_n(we_n), .rs(rs), .rx(rx),
    .din(din), .dout(dout), .tx(tx), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    pclk = (pph == 2);
    pph = (pph + 1) % 3;
  end

  always @(posedge clk) if (pclk) tick_count++;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic r, input logic [7:0] d);
    cs_n = 0; we_n = 0; rs = r; din = d;
    @(negedge clk);
    cs_n = 1; we_n = 1;
  endtask

  task automatic rd_reg(input logic r, output logic [7:0] v);
    cs_n = 0; we_n = 1; rs = r;
    @(negedge clk);
    cs_n = 1;
    v = dout;
  endtask

  task automatic wait_start(output int t0, output int w);
    w = 0;
    while (tx !== 1'b0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    t0 = tick_count;
  endtask

  task automatic tx_check(input int t0, input logic [7:0] b,
                          input string tag);
    logic [9:0] fr;
    int bad, el;
    fr = {1'b1, b, 1'b0};
    bad = 0;
    el = tick_count - t0;
    for (int i = 0; i < 1000 && el < 10 * DIV; i++) begin
      if (tx !== fr[el / DIV]) bad++;
      @(negedge clk);
      el = tick_count - t0;
    end
    chk({tag, "_bits"}, bad, 0);
    chk({tag, "_len"}, el, 10 * DIV);
    chk({tag, "_stop"}, {31'd0, tx}, 1);
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = tick_count;
    for (int i = 0; i < 1000 && tick_count - t < n; i++)
      @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      wait_ticks(DIV);
    end
    rx = 1'b1;
    wait_ticks(2);
  endtask

  initial begin
    logic [7:0] v;
    int t0, w;
    cs_n = 1; we_n = 1; rs = 0; din = 0; rx = 1; reset_n = 0;
    repeat (4) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_irq", {31'd0, irq_n}, 1);
    chk("rst_dout", dout, 8'h00);
    reset_n = 1;
    @(negedge clk);
    rd_reg(0, v); chk("rst_status", v, 8'h02);

    wr_reg(0, 8'h03);
    wr_reg(0, 8'h00);
    rd_reg(0, v); chk("mr_status", v, 8'h02);

    wr_reg(1, 8'h55);
    rd_reg(0, v); chk("tdre_wr", v, 8'h00);
    chk("tx55_start", {31'd0, tx}, 0);
    t0 = tick_count;
    rd_reg(0, v); chk("tdre_after", v, 8'h02);
    tx_check(t0, 8'h55, "tx55");

    wr_reg(1, 8'h11);
    wait_start(t0, w); chk("tx11_lat", w, 1);
    wr_reg(1, 8'h22);
    wr_reg(1, 8'h33);
    tx_check(t0, 8'h11, "tx11");
    wait_start(t0, w); chk("tx_gap", w, 1);
    tx_check(t0, 8'h33, "tx33");

    wr_reg(1, 8'h00);
    wait_start(t0, w);
    repeat (20) @(negedge clk);
    chk("mr_mid", {31'd0, tx}, 0);
    wr_reg(0, 8'h03);
    chk("mr_tx", {31'd0, tx}, 1);
    rd_reg(0, v); chk("mr_stat", v, 8'h02);
    repeat (60) @(negedge clk);
    chk("mr_quiet", {31'd0, tx}, 1);

    wr_reg(0, 8'h20);
    chk("tie_irq", {31'd0, irq_n}, 0);
    rd_reg(0, v); chk("tie_stat", v, 8'h82);
    wr_reg(1, 8'h0F);
    chk("tie_wr", {31'd0, irq_n}, 1);
    @(negedge clk);
    chk("tie_xfer", {31'd0, irq_n}, 0);
    t0 = tick_count;
    tx_check(t0, 8'h0F, "tx0f");
    wr_reg(0, 8'h60);
    chk("tie_11", {31'd0, irq_n}, 1);
    wr_reg(0, 8'h00);

`ifdef ACIA_RX_EN
    rx_send(8'hA3, 1'b1);
    rd_reg(0, v); chk("rx_stat", v, 8'h03);
    rd_reg(1, v); chk("rx_data", v, 8'hA3);
    rd_reg(0, v); chk("rx_clr", v, 8'h02);

    rx_send(8'h5A, 1'b1);
    rx_send(8'hC6, 1'b1);
    rd_reg(0, v); chk("ovrn_stat", v, 8'h23);
    rd_reg(1, v); chk("ovrn_data", v, 8'hC6);
    rd_reg(0, v); chk("ovrn_clr", v, 8'h02);

    rx_send(8'h3C, 1'b0);
    rd_reg(0, v); chk("fe_stat", v, 8'h13);
    rd_reg(1, v); chk("fe_data", v, 8'h3C);
    rd_reg(0, v); chk("fe_clr", v, 8'h02);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(2 * DIV);
    rd_reg(0, v); chk("glitch", v, 8'h02);

    wr_reg(0, 8'h80);
    rx_send(8'h81, 1'b1);
    chk("rie_irq", {31'd0, irq_n}, 0);
    rd_reg(0, v); chk("rie_stat", v, 8'h83);
    rd_reg(1, v); chk("rie_data", v, 8'h81);
    chk("rie_clr", {31'd0, irq_n}, 1);
    wr_reg(0, 8'h00);
`else
    wr_reg(0, 8'h80);
    rx_send(8'hA3, 1'b1);
    rd_reg(0, v); chk("norx_stat", v, 8'h02);
    rd_reg(1, v); chk("norx_data", v, 8'h00);
    chk("norx_irq", {31'd0, irq_n}, 1);
    wr_reg(0, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
